// File: rtl/noc_pkg.sv
// Shared types and helpers for the round-robin NoC collector.
package noc_pkg;

  // Default channel count; the top module parameter starts from this value.
  localparam int NOC_CPU_NB = 4;

  // $clog2 that never returns 0, so a single channel still gets a 1-bit source id.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Source channel id for the default channel count.
  typedef logic [clog2_min1(NOC_CPU_NB)-1:0] src_t;

  // Output arbitration state: OPEN lets the round-robin scan pick freely,
  // HOLD pins the grant to a stalled beat until downstream accepts it.
  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_rr_collector_if.sv
// Bundle of the per-channel inputs and the merged output stream.
//
// Handshake: a beat moves across a valid/ready pair on a rising clock edge
// where valid and ready are both 1. Ready never depends combinationally on
// valid. Once valid is raised with a payload, valid, payload and source
// stay unchanged until the beat is taken.
interface noc_rr_collector_if #(
  parameter int CPU_NB = 4,
  parameter int DATA_W = 64
);
  import noc_pkg::*;

  localparam int SRC_W = clog2_min1(CPU_NB);

  logic [CPU_NB-1:0]             data_vld;
  logic [CPU_NB-1:0]             data_rdy;
  logic [CPU_NB-1:0][DATA_W-1:0] data;
  logic                          out_vld;
  logic                          out_rdy;
  logic [DATA_W-1:0]             out_data;
  logic [SRC_W-1:0]              out_src;
  logic [CPU_NB-1:0]             done;
  logic                          all_done;

  // Collector side.
  modport slave (
    input  data_vld, data, out_rdy,
    output data_rdy, out_vld, out_data, out_src, done, all_done
  );

  // CPU array / downstream side.
  modport master (
    output data_vld, data, out_rdy,
    input  data_rdy, out_vld, out_data, out_src, done, all_done
  );

endinterface

// File: rtl/noc_chan_fifo.sv
// Per-channel synchronous FIFO. Pointers carry an extra wrap bit so that
// full and empty are distinguishable without an occupancy counter.
module noc_chan_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; pushes into a full FIFO and pops from an
  // empty one are ignored.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers; reset drops any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/noc_rr_collector.sv
// Collects CPU_NB valid/ready channels into per-channel FIFOs and merges them
// round-robin onto one tagged output stream, tracking per-channel completion.
module noc_rr_collector
  import noc_pkg::*;
#(
  parameter int CPU_NB         = NOC_CPU_NB,
  parameter int DATA_W         = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TRANSACTION_NB = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  noc_rr_collector_if.slave   bus,
  output arb_state_t          dbg_arb_state
);

  localparam int SRC_W = clog2_min1(CPU_NB);
  localparam int CNT_W = $clog2(TRANSACTION_NB + 1);

  logic [CPU_NB-1:0] push, pop, full, empty;
  logic [DATA_W-1:0] head [CPU_NB];

  arb_state_t        state_q, state_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;
  logic [SRC_W-1:0]  lock_src_q, lock_src_d;
  logic [SRC_W-1:0]  scan_src, grant;
  logic [SRC_W:0]    scan_idx;
  logic              scan_found;
  logic              accept;

  logic [CNT_W-1:0]  cnt_q [CPU_NB];
  logic [CNT_W-1:0]  cnt_d [CPU_NB];
  logic [CPU_NB-1:0] done_q, done_d;

  // Ready is purely a function of registered FIFO state.
  assign bus.data_rdy = ~full;
  assign push         = bus.data_vld & ~full;

  for (genvar g = 0; g < CPU_NB; g++) begin : g_chan
    noc_chan_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (bus.data[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (head[g])
    );
  end

  // Round-robin scan: first non-empty channel after the last accepted one.
  always_comb begin
    scan_src   = '0;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int k = 1; k <= CPU_NB; k++) begin
      scan_idx = {1'b0, last_grant_q} + (SRC_W+1)'(k);
      if (scan_idx >= (SRC_W+1)'(CPU_NB)) begin
        scan_idx = scan_idx - (SRC_W+1)'(CPU_NB);
      end
      if (!scan_found && !empty[scan_idx[SRC_W-1:0]]) begin
        scan_found = 1'b1;
        scan_src   = scan_idx[SRC_W-1:0];
      end
    end
  end

  // Output mux and pop: a held grant overrides the scan so a stalled beat
  // cannot be replaced by a channel that became valid later.
  always_comb begin
    grant        = (state_q == ARB_HOLD) ? lock_src_q : scan_src;
    bus.out_vld  = ~(&empty);
    accept       = bus.out_vld && bus.out_rdy;
    bus.out_src  = bus.out_vld ? grant : '0;
    bus.out_data = bus.out_vld ? head[grant] : '0;
    pop          = '0;
    if (accept) begin
      pop[grant] = 1'b1;
    end
  end

  // Arbitration next state: lock on a stalled beat, release on accept.
  always_comb begin
    state_d      = state_q;
    lock_src_d   = lock_src_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_OPEN: begin
        if (bus.out_vld && !bus.out_rdy) begin
          state_d    = ARB_HOLD;
          lock_src_d = grant;
        end
      end
      ARB_HOLD: begin
        if (bus.out_rdy) begin
          state_d = ARB_OPEN;
        end
      end
      default: state_d = ARB_OPEN;
    endcase
    if (accept) begin
      last_grant_d = grant;
    end
  end

  // Arbitration registers; after reset channel 0 is next in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_OPEN;
      lock_src_q   <= '0;
      last_grant_q <= SRC_W'(CPU_NB - 1);
    end else begin
      state_q      <= state_d;
      lock_src_q   <= lock_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Saturating accept counters; done latches one cycle after saturation.
  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      cnt_d[i]  = cnt_q[i];
      done_d[i] = done_q[i] | (cnt_q[i] == CNT_W'(TRANSACTION_NB));
      if (pop[i] && (cnt_q[i] != CNT_W'(TRANSACTION_NB))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      for (int i = 0; i < CPU_NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      done_q <= done_d;
      for (int i = 0; i < CPU_NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.all_done  = &done_q;
  assign dbg_arb_state = state_q;

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_vld && !bus.out_rdy) |=>
      (bus.out_vld && $stable(bus.out_src) && $stable(bus.out_data)));

endmodule

// File: doc/noc_rr_collector.md
Name: noc_rr_collector

Overview:
Parametrised successor to the per-CPU NoC sink. It accepts valid/ready traffic from CPU_NB CPU channels and buffers each channel in its own FIFO. It merges the channels round-robin onto one tagged output stream and keeps per-channel and global transaction-completion status. It sits between the CPU array and the downstream NoC link/monitor; backpressure comes from real FIFO occupancy instead of random ready.

Parameters:
CPU_NB, 4, number of CPU input channels (1..16)
DATA_W, 64, payload width in bits
FIFO_DEPTH, 4, entries per channel FIFO (power of two, >=2)
TRANSACTION_NB, 10, output transactions per channel that mark that channel done

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
data_vld  input  [CPU_NB] x 1  per-channel input valid
data_rdy  output  [CPU_NB] x 1  per-channel input ready
data  input  [CPU_NB] x DATA_W  per-channel payload
out_vld  output  1  merged output valid
out_rdy  input  1  downstream ready
out_data  output  DATA_W  merged payload
out_src  output  $clog2(CPU_NB) (min 1)  source channel of out_data
done  output  CPU_NB  per-channel TRANSACTION_NB reached
all_done  output  1  &done

Behaviour:
- Reset is asynchronous assert, synchronous deassert by the environment. It empties all FIFOs, clears counters and done, clears the lock, and sets the RR pointer so channel 0 has top priority. Outputs in reset: data_rdy all 1, out_vld 0, out_data 0, out_src 0, done 0, all_done 0.
- Reset mid-operation: in-flight FIFO contents are dropped with no output; counters restart from 0.
- Input: data_rdy[i] = !full[i], from registered state only, with no combinational path from data_vld. A push happens when data_vld[i] && data_rdy[i].
- FIFO timing: minimum latency is 1 cycle (a push at edge N is visible on the output after edge N). There is no bypass. When full, data_rdy is 0, so there is no push-while-full even if a pop occurs in the same cycle. Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- Arbitration: out_vld = at least one FIFO non-empty.
  - Grant goes to the first non-empty channel scanning from (last_grant+1) mod CPU_NB.
  - out_data/out_src come from the granted FIFO head.
- Stability rule: when out_vld && !out_rdy, the grant is locked. out_src and out_data must not change until accepted, even if a higher-priority channel fills.
- Accept: out_vld && out_rdy pops the granted FIFO, sets last_grant = granted channel, and releases the lock.
- Simultaneous push and pop on the same channel in one cycle is legal; occupancy is unchanged.
- Fairness: with all channels continuously non-empty and out_rdy=1, grants rotate 0,1,..,CPU_NB-1 with no channel skipped.
- Counters: cnt[i] (width $clog2(TRANSACTION_NB+1)) increments on each accept from channel i and saturates at TRANSACTION_NB.
  - done[i] is registered and set on the cycle after cnt[i] reaches TRANSACTION_NB; it is sticky until reset.
  - Traffic after done is still forwarded, but the counter does not increment.
- Simulation-only checks: assertion that out_src/out_data stay stable while stalled; assertion that there is no push when full. No $finish inside the block.

Decomposition:
- Package noc_pkg: src_t typedef sized from CPU_NB, and a function clog2_min1. DATA_W stays a module parameter.
- Sub-module noc_chan_fifo (DATA_W, FIFO_DEPTH): synchronous FIFO with push/pop/full/empty/head. It is instantiated CPU_NB times in a generate loop. The arbiter, lock and counters stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with data_vld=1 -> data_rdy all 1, out_vld=0, done=0, no pushes recorded; deassert -> first out_vld no earlier than 1 cycle after the first push.
- Backpressure fill: out_rdy=0, channel 2 pushes 0x2000..0x2005 with DEPTH=4 -> 4 pushes accepted, data_rdy[2]=0 after the 4th; out_src=2 and out_data=0x2000 held stable throughout.
- Lock: channel 3 pending and stalled for 5 cycles, then channel 0 becomes valid -> out_src stays 3 until out_rdy=1; the next grant is 0.
- Round-robin: all 4 channels saturated with data 0xC<i>_<k>, out_rdy=1 -> out_src sequence 0,1,2,3,0,1,..., and per-channel data stays in order.
- Completion: each channel sends 12 words, out_rdy random at 50% -> done[i] rises exactly after its 10th accept; all_done rises after the last channel's 10th; all 48 words are forwarded.
- Reset mid-run: assert rst_n=0 with FIFOs half full and cnt=5 -> FIFOs emptied, counters 0; after release, 10 new accepts per channel are needed for done.
